hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the maximum number of memory-wait cycles before an error (legal range 2..255).
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of the stall performance counter.
REQ-003 SHALL have port clk  input  1  pipeline clock, rising edge active.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port rs_d, rt_d  input  5 each  source register numbers in the decode stage.
REQ-006 SHALL have port rt_e  input  5  destination of the instruction in the execute stage.
REQ-007 SHALL have port memtoreg_e  input  1  execute-stage instruction is a load.
REQ-008 SHALL have port pcsrc_d  input  1  branch or jump taken, resolved in the decode stage.
REQ-009 SHALL have port dmem_req_m  input  1  memory stage is accessing data memory.
REQ-010 SHALL have port dmem_ready  input  1  data memory completes the access this cycle.
REQ-011 SHALL have ports stall_f, stall_d, stall_e, stall_m  output  1 each  hold enables for the pipeline registers, where 1 means hold.
REQ-012 SHALL have ports flush_d, flush_e  output  1 each  synchronous clears that insert a bubble into the decode/execute registers.
REQ-013 SHALL have port err  output  1  sticky memory-timeout error flag.
REQ-014 SHALL have port stall_cnt  output  CNT_W  count of stall cycles.

Function
REQ-015 SHALL implement FSM states RUN, MEM_WAIT and ERR, held in a registered state.
REQ-016 In RUN, with dmem_req_m=1 and dmem_ready=0, SHALL assert stall_f, stall_d, stall_e and stall_m in the same cycle, and SHALL move to MEM_WAIT.
REQ-017 In RUN, with no memory wait, SHALL detect load-use when memtoreg_e=1, rt_e!=0, and (rt_e==rs_d or rt_e==rt_d).
REQ-018 On load-use, SHALL assert stall_f, stall_d and flush_e for exactly that cycle (one bubble), with no state change.
REQ-019 In RUN, with pcsrc_d=1 and neither a memory wait nor load-use, SHALL assert flush_d for one cycle.
REQ-020 SHALL apply priority memory-wait > load-use > branch flush; when load-use and pcsrc_d occur together, flush_d SHALL be 0.
REQ-021 In MEM_WAIT, SHALL hold all four stalls at 1, hold both flushes at 0, and increment the wait counter each cycle.
REQ-022 In MEM_WAIT, dmem_ready=1 SHALL deassert all stalls in that cycle and return to RUN next cycle, with the wait counter cleared.
REQ-023 In MEM_WAIT, if the wait counter reaches TIMEOUT-1 without dmem_ready, SHALL go to ERR; dmem_ready takes priority on the same cycle.
REQ-024 In ERR, SHALL hold all four stalls at 1 and err=1, leaving ERR only on reset.
REQ-025 Register 0 as a destination SHALL never cause a stall.

Reset
REQ-026 While reset=0, SHALL force state RUN, wait counter 0, stall_cnt 0 and err 0 immediately.
REQ-027 Reset asserted mid-wait SHALL abort the wait; outputs SHALL then follow RUN decoding of the current inputs.
REQ-028 Reset deassertion SHALL take effect on the next rising clk edge.

Configuration
REQ-029 With macro HAZARD_PERF_EN defined, stall_cnt SHALL increment by 1 on every cycle with stall_f=1, saturating at all-ones.
REQ-030 Without HAZARD_PERF_EN, stall_cnt SHALL be constant 0 and no counter flops SHALL be inferred.

Structure
REQ-031 The shared package SHALL hold the FSM state encoding typedef (RUN=2'b00, MEM_WAIT=2'b01, ERR=2'b10) and the register-zero constant.
REQ-032 Load-use detection SHALL be a combinational sub-module named hazard_detect.
REQ-033 All other logic SHALL stay in hazard_ctrl.

Verification
REQ-034 Load-use: memtoreg_e=1, rt_e=5, rs_d=5 -> exactly one cycle of stall_f=stall_d=flush_e=1, then all outputs 0.
REQ-035 Register zero: memtoreg_e=1, rt_e=0, rs_d=0 -> no stall and no flush.
REQ-036 Memory wait: dmem_req_m=1, dmem_ready low for 3 cycles, then high -> stalls high for 3 cycles, 0 in the ready cycle; with HAZARD_PERF_EN, stall_cnt=3.
REQ-037 Timeout: TIMEOUT=4, dmem_ready held 0 -> ERR entered, err=1 and all stalls held until reset=0.
REQ-038 Simultaneous events: load-use plus pcsrc_d=1 -> flush_d=0 and flush_e=1; a wait plus load-use -> only the four stalls asserted.
REQ-039 Reset mid-wait: reset=0 during MEM_WAIT -> state RUN, err=0, stall_cnt=0 asynchronously.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding
// and the architectural zero-register number.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ERR      = 2'b10
  } state_t;

  localparam int          REG_W    = 5;
  localparam logic [4:0]  REG_ZERO = 5'd0;
  localparam int          WAIT_W   = 8;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detector: a load in execute whose destination
// feeds either decode-stage source operand. Register zero never matches.
module hazard_detect
  import hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] rs_d,
  input  logic [REG_W-1:0] rt_d,
  input  logic [REG_W-1:0] rt_e,
  input  logic             memtoreg_e,
  output logic             load_use
);

  assign load_use = memtoreg_e && (rt_e != REG_ZERO) &&
                    ((rt_e == rs_d) || (rt_e == rt_d));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait stalls with timeout, load-use
// bubbles and branch flushes. Define HAZARD_PERF_EN for the stall counter.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] rs_d,
  input  logic [REG_W-1:0] rt_d,
  input  logic [REG_W-1:0] rt_e,
  input  logic             memtoreg_e,
  input  logic             pcsrc_d,
  input  logic             dmem_req_m,
  input  logic             dmem_ready,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             flush_d,
  output logic             flush_e,
  output logic             err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic              load_use;
  logic              mem_wait;

  hazard_detect u_detect (
    .rs_d       (rs_d),
    .rt_d       (rt_d),
    .rt_e       (rt_e),
    .memtoreg_e (memtoreg_e),
    .load_use   (load_use)
  );

  assign mem_wait = dmem_req_m && !dmem_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case can leave a value held and infer a latch.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    stall_f      = 1'b0;
    stall_d      = 1'b0;
    stall_e      = 1'b0;
    stall_m      = 1'b0;
    flush_d      = 1'b0;
    flush_e      = 1'b0;
    unique case (state)
      RUN: begin
        wait_cnt_nxt = '0;
        // Priority: memory wait, then load-use bubble, then branch flush.
        if (mem_wait) begin
          {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
          state_nxt = MEM_WAIT;
        end else if (load_use) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
        end else if (pcsrc_d) begin
          flush_d = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end else begin
          {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
          if (wait_cnt == WAIT_LAST) begin
            state_nxt = ERR;
          end else begin
            wait_cnt_nxt = wait_cnt + WAIT_W'(1);
          end
        end
      end
      ERR: begin
        {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  assign err = (state == ERR);

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else if (stall_f && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule
